axis_accumulator: RTL and testbench

Downstream stage of the two-input AXI-Stream example datapath. It consumes the single result stream and sums groups of ACC_LEN beats, or shorter groups closed by `s_axis_tlast`. For each group it emits one widened sum on its own AXI-Stream master port, together with the number of beats in the group. It sits between the example block's master port and the sink or scoreboard.

---
 rtl/axis_accumulator_pkg.sv | 19 +
 rtl/axis_acc_adder.sv | 31 +++
 rtl/axis_accumulator.sv | 123 ++++++++++++
 tb/tb_axis_accumulator.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_accumulator_pkg.sv
// Shared types and helpers for the AXI-Stream group accumulator.
// Optional feature macro: AXIS_ACC_SATURATE_EN.
package axis_accumulator_pkg;

  // Upper bounds for the packed output beat; instances use the low bits only.
  localparam int unsigned AccWidthMax   = 512;
  localparam int unsigned CountWidthMax = 32;

  function automatic int unsigned count_width(input int unsigned acc_len);
    return $clog2(acc_len + 1);
  endfunction

  typedef struct packed {
    logic [AccWidthMax-1:0]   tdata;
    logic [CountWidthMax-1:0] tcount;
    logic                     tuser;
  } acc_beat_t;

endpackage

// File: rtl/axis_acc_adder.sv
// Combinational zero-extend-and-add of one beat onto the running sum.
// With AXIS_ACC_SATURATE_EN the sum clamps at all-ones and reports a sticky flag.
module axis_acc_adder
  import axis_accumulator_pkg::*;
#(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AccWidth  = 64
) (
  input  logic [AccWidth-1:0]  acc,
  input  logic [DataWidth-1:0] beat,
  output logic [AccWidth-1:0]  sum
`ifdef AXIS_ACC_SATURATE_EN
  ,
  input  logic                 sat_in,
  output logic                 sat_out
`endif
);

`ifdef AXIS_ACC_SATURATE_EN
  localparam int unsigned SumWidth = AccWidth + 1;

  logic [AccWidth:0] full;

  assign full    = {1'b0, acc} + SumWidth'(beat);
  assign sum     = full[AccWidth] ? '1 : full[AccWidth-1:0];
  assign sat_out = sat_in | full[AccWidth];
`else
  assign sum = acc + AccWidth'(beat);
`endif

endmodule

// File: rtl/axis_accumulator.sv
// Sums groups of ACC_LEN beats (or shorter groups closed by tlast) into one widened output beat.
// Optional feature macro: AXIS_ACC_SATURATE_EN (saturating sum, flag on m_axis_tuser).
module axis_accumulator
  import axis_accumulator_pkg::*;
#(
  parameter int unsigned TDATA_WIDTH_BYTES = 4,
  parameter int unsigned ACC_WIDTH_BYTES   = 8,
  parameter int unsigned ACC_LEN           = 8
) (
  input  logic                                 aclk,
  input  logic                                 reset,
  input  logic                                 s_axis_tvalid,
  output logic                                 s_axis_tready,
  input  logic [TDATA_WIDTH_BYTES*8-1:0]       s_axis_tdata,
  input  logic                                 s_axis_tlast,
  output logic                                 m_axis_tvalid,
  input  logic                                 m_axis_tready,
  output logic [ACC_WIDTH_BYTES*8-1:0]         m_axis_tdata,
  output logic [count_width(ACC_LEN)-1:0]      m_axis_tcount
`ifdef AXIS_ACC_SATURATE_EN
  ,
  output logic                                 m_axis_tuser
`endif
);

  localparam int unsigned DataW   = TDATA_WIDTH_BYTES * 8;
  localparam int unsigned AccW    = ACC_WIDTH_BYTES * 8;
  localparam int unsigned CntW    = count_width(ACC_LEN);
  localparam int unsigned LastCnt = ACC_LEN - 1;

  logic [AccW-1:0] acc_q, acc_d, sum;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tvalid_q, tvalid_d;
  acc_beat_t       out_q, out_d;
  logic            accept, complete;
  logic            sat_next;

  assign s_axis_tready = !reset && (!tvalid_q || m_axis_tready);
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign complete      = accept && (s_axis_tlast || (cnt_q == CntW'(LastCnt)));

`ifdef AXIS_ACC_SATURATE_EN
  logic sat_q, sat_d;

  axis_acc_adder #(
    .DataWidth (DataW),
    .AccWidth  (AccW)
  ) u_adder (
    .acc     (acc_q),
    .beat    (s_axis_tdata),
    .sum     (sum),
    .sat_in  (sat_q),
    .sat_out (sat_next)
  );

  // Sticky per-group flag; a completing beat hands it to the output and starts clean.
  always_comb begin
    sat_d = sat_q;
    if (accept) sat_d = complete ? 1'b0 : sat_next;
  end

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) sat_q <= 1'b0;
    else       sat_q <= sat_d;
  end

  assign m_axis_tuser = out_q.tuser;
`else
  axis_acc_adder #(
    .DataWidth (DataW),
    .AccWidth  (AccW)
  ) u_adder (
    .acc  (acc_q),
    .beat (s_axis_tdata),
    .sum  (sum)
  );

  assign sat_next = 1'b0;
`endif

  always_comb begin
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    tvalid_d = tvalid_q;
    out_d    = out_q;
    if (tvalid_q && m_axis_tready) tvalid_d = 1'b0;
    // A completion in the pop cycle overrides the clear, keeping tvalid high.
    if (complete) begin
      acc_d        = '0;
      cnt_d        = '0;
      tvalid_d     = 1'b1;
      out_d.tdata  = AccWidthMax'(sum);
      out_d.tcount = CountWidthMax'(cnt_q + 1'b1);
      out_d.tuser  = sat_next;
    end else if (accept) begin
      acc_d = sum;
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      tvalid_q <= 1'b0;
      out_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      tvalid_q <= tvalid_d;
      out_q    <= out_d;
    end
  end

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = out_q.tdata[AccW-1:0];
  assign m_axis_tcount = out_q.tcount[CntW-1:0];

  // Bits above this instance's widths are always zero.
  logic unused_out;
  assign unused_out = ^out_q;

endmodule

// File: tb/tb_axis_accumulator.sv
// Randomized and directed bench for axis_accumulator against a group-sum reference model.
// Honours AXIS_ACC_SATURATE_EN when defined.
module tb_axis_accumulator;

  localparam int unsigned MainLen = 4;

  logic aclk;
  logic reset;

  // Main instance: ACC_LEN=4, 32-bit beats, 64-bit sum.
  logic        s_valid, s_ready, s_last, m_valid, m_ready;
  logic [31:0] s_data;
  logic [63:0] m_data;
  logic [2:0]  m_count;
  // Narrow instance: ACC_LEN=4, 32-bit sum.
  logic        n_s_valid, n_s_ready, n_s_last, n_m_valid, n_m_ready;
  logic [31:0] n_s_data, n_m_data;
  logic [2:0]  n_m_count;
  // Single-beat instance: ACC_LEN=1.
  logic        o_s_valid, o_s_ready, o_s_last, o_m_valid, o_m_ready;
  logic [31:0] o_s_data;
  logic [63:0] o_m_data;
  logic [0:0]  o_m_count;
`ifdef AXIS_ACC_SATURATE_EN
  logic        m_user, n_m_user, o_m_user;
`endif

  axis_accumulator #(
    .TDATA_WIDTH_BYTES (4),
    .ACC_WIDTH_BYTES   (8),
    .ACC_LEN           (MainLen)
  ) u_dut (
    .aclk          (aclk),
    .reset         (reset),
    .s_axis_tvalid (s_valid),
    .s_axis_tready (s_ready),
    .s_axis_tdata  (s_data),
    .s_axis_tlast  (s_last),
    .m_axis_tvalid (m_valid),
    .m_axis_tready (m_ready),
    .m_axis_tdata  (m_data),
    .m_axis_tcount (m_count)
`ifdef AXIS_ACC_SATURATE_EN
    ,
    .m_axis_tuser  (m_user)
`endif
  );

  axis_accumulator #(
    .TDATA_WIDTH_BYTES (4),
    .ACC_WIDTH_BYTES   (4),
    .ACC_LEN           (4)
  ) u_dut_narrow (
    .aclk          (aclk),
    .reset         (reset),
    .s_axis_tvalid (n_s_valid),
    .s_axis_tready (n_s_ready),
    .s_axis_tdata  (n_s_data),
    .s_axis_tlast  (n_s_last),
    .m_axis_tvalid (n_m_valid),
    .m_axis_tready (n_m_ready),
    .m_axis_tdata  (n_m_data),
    .m_axis_tcount (n_m_count)
`ifdef AXIS_ACC_SATURATE_EN
    ,
    .m_axis_tuser  (n_m_user)
`endif
  );

  axis_accumulator #(
    .TDATA_WIDTH_BYTES (4),
    .ACC_WIDTH_BYTES   (8),
    .ACC_LEN           (1)
  ) u_dut_one (
    .aclk          (aclk),
    .reset         (reset),
    .s_axis_tvalid (o_s_valid),
    .s_axis_tready (o_s_ready),
    .s_axis_tdata  (o_s_data),
    .s_axis_tlast  (o_s_last),
    .m_axis_tvalid (o_m_valid),
    .m_axis_tready (o_m_ready),
    .m_axis_tdata  (o_m_data),
    .m_axis_tcount (o_m_count)
`ifdef AXIS_ACC_SATURATE_EN
    ,
    .m_axis_tuser  (o_m_user)
`endif
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int unsigned cyc;
  always @(posedge aclk) cyc++;

  int unsigned n_cmp;
  int unsigned n_err;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    end
  endtask

  // Reference: the group result from the exact integer total of its beats.
  function automatic logic [64:0] ref_out(input logic [127:0] total, input int unsigned bits);
    logic [127:0] lim;
    lim = 128'd1 << bits;
`ifdef AXIS_ACC_SATURATE_EN
    if (total >= lim) return {1'b1, 64'(lim - 1)};
    return {1'b0, total[63:0]};
`else
    return {1'b0, 64'(total % lim)};
`endif
  endfunction

  typedef struct {
    logic [63:0] data;
    int unsigned cnt;
    logic        user;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         e;
  logic [64:0]  r;
  logic [127:0] grp_total;
  int unsigned  grp_cnt;
  logic         hold_prev;
  logic [63:0]  hold_data;
  logic [2:0]   hold_cnt;

  // Scoreboard for the main instance, sampled on the falling edge.
  always @(negedge aclk) begin
    if (reset) begin
      check_eq("rst_m_valid", m_valid, 0);
      check_eq("rst_m_data", m_data, 0);
      check_eq("rst_m_count", m_count, 0);
      check_eq("rst_s_ready", s_ready, 0);
`ifdef AXIS_ACC_SATURATE_EN
      check_eq("rst_m_user", m_user, 0);
`endif
      exp_q.delete();
      grp_total = '0;
      grp_cnt   = 0;
      hold_prev = 1'b0;
    end else begin
      check_eq("s_ready_rule", s_ready, !m_valid || m_ready);
      if (hold_prev) begin
        check_eq("hold_valid", m_valid, 1);
        check_eq("hold_data", m_data, hold_data);
        check_eq("hold_count", m_count, hold_cnt);
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_out", m_valid, 0);
        end else begin
          e = exp_q.pop_front();
          check_eq("out_data", m_data, e.data);
          check_eq("out_count", m_count, e.cnt);
`ifdef AXIS_ACC_SATURATE_EN
          check_eq("out_user", m_user, e.user);
`endif
        end
      end
      if (s_valid && s_ready) begin
        grp_total += s_data;
        grp_cnt++;
        if (s_last || grp_cnt == MainLen) begin
          r = ref_out(grp_total, 64);
          exp_q.push_back('{data: r[63:0], cnt: grp_cnt, user: r[64]});
          grp_total = '0;
          grp_cnt   = 0;
        end
      end
      hold_prev = m_valid && !m_ready;
      hold_data = m_data;
      hold_cnt  = m_count;
    end
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  // Call just after a rising edge; returns just after the edge that takes the beat.
  task automatic send(input logic [31:0] d, input logic l);
    logic taken;
    taken   = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    for (int i = 0; i < 50 && !taken; i++) begin
      @(negedge aclk);
      taken = s_ready;
      step();
    end
    if (!taken) check_eq("send_timeout", s_ready, 1);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  logic [31:0]  nar_beats [8];
  logic [31:0]  one_beats [6];
  logic [127:0] n_total;
  logic [64:0]  n_ref;
  logic         acc_now;
  int unsigned  c0;

  initial begin
    reset     = 1'b1;
    s_valid   = 1'b0; s_data   = '0; s_last   = 1'b0; m_ready   = 1'b1;
    n_s_valid = 1'b0; n_s_data = '0; n_s_last = 1'b0; n_m_ready = 1'b1;
    o_s_valid = 1'b0; o_s_data = '0; o_s_last = 1'b0; o_m_ready = 1'b1;
    n_cmp = 0;
    n_err = 0;
    repeat (3) step();
    reset = 1'b0;
    @(negedge aclk);
    check_eq("release_ready", s_ready, 1);
    step();

    // Full group, back to back, single-cycle output pulse.
    c0 = cyc;
    send(1, 0); send(2, 0); send(3, 0); send(4, 0);
    check_eq("throughput_cycles", cyc - c0, 4);
    @(negedge aclk);
    check_eq("lat_valid", m_valid, 1);
    check_eq("lat_data", m_data, 10);
    check_eq("lat_count", m_count, 4);
    @(negedge aclk);
    check_eq("pulse_len", m_valid, 0);
    step();

    // tlast-closed short group, then a full one.
    send(5, 0); send(7, 1);
    send(1, 0); send(1, 0); send(1, 0); send(1, 0);
    repeat (3) step();

    // Backpressure with a completing beat waiting.
    m_ready = 1'b0;
    send(2, 0); send(2, 0); send(2, 0); send(2, 0);
    s_valid = 1'b1; s_data = 3; s_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      check_eq("bp_s_ready", s_ready, 0);
      check_eq("bp_valid", m_valid, 1);
      check_eq("bp_data", m_data, 8);
      check_eq("bp_count", m_count, 4);
    end
    step();
    m_ready = 1'b1;
    @(negedge aclk);
    check_eq("pop_s_ready", s_ready, 1);
    step();
    s_valid = 1'b0; s_last = 1'b0;
    @(negedge aclk);
    check_eq("pop_load_valid", m_valid, 1);
    check_eq("pop_load_data", m_data, 3);
    check_eq("pop_load_count", m_count, 1);
    repeat (2) step();

    // Reset mid-group discards the partial sum.
    send(1, 0); send(1, 0);
    reset = 1'b1;
    @(negedge aclk);
    @(negedge aclk);
    step();
    reset = 1'b0;
    @(negedge aclk);
    check_eq("rst_release_ready", s_ready, 1);
    check_eq("rst_no_output", m_valid, 0);
    step();
    send(1, 0); send(1, 0); send(1, 0); send(1, 0);
    repeat (3) step();

    // Narrow sum: wrap or saturate, then a clean group.
    nar_beats = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h1, 32'h1, 32'h1, 32'h1};
    n_total   = '0;
    @(negedge aclk);
    for (int i = 0; i < 8; i++) begin
      n_s_valid = 1'b1;
      n_s_data  = nar_beats[i];
      n_total  += nar_beats[i];
      @(negedge aclk);
      check_eq("nar_valid", n_m_valid, (i % 4) == 3);
      if ((i % 4) == 3) begin
        n_ref = ref_out(n_total, 32);
        check_eq("nar_data", n_m_data, n_ref[63:0]);
        check_eq("nar_count", n_m_count, 4);
`ifdef AXIS_ACC_SATURATE_EN
        check_eq("nar_user", n_m_user, n_ref[64]);
`endif
        n_total = '0;
      end
    end
    n_s_valid = 1'b0;

    // ACC_LEN=1: every beat is its own group.
    one_beats = '{32'd9, 32'd3, $urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 6; i++) begin
      o_s_valid = 1'b1;
      o_s_data  = one_beats[i];
      o_s_last  = 1'($urandom_range(0, 1));
      @(negedge aclk);
      check_eq("one_valid", o_m_valid, 1);
      check_eq("one_data", o_m_data, {32'h0, one_beats[i]});
      check_eq("one_count", o_m_count, 1);
      check_eq("one_s_ready", o_s_ready, 1);
    end
    o_s_valid = 1'b0;
    o_s_last  = 1'b0;
    @(negedge aclk);
    check_eq("one_idle", o_m_valid, 0);

    // Random traffic and backpressure on the main instance.
    for (int i = 0; i < 400; i++) begin
      @(negedge aclk);
      acc_now = s_valid && s_ready;
      step();
      if (!s_valid || acc_now) begin
        s_valid = ($urandom_range(0, 3) != 0);
        s_data  = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 15));
        s_last  = ($urandom_range(0, 4) == 0);
      end
      m_ready = ($urandom_range(0, 9) < 7);
    end
    step();
    s_valid = 1'b0;
    s_last  = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge aclk);
      if (exp_q.size() == 0 && !m_valid) break;
    end
    check_eq("drain_queue", exp_q.size(), 0);
    check_eq("drain_valid", m_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
